// File: rtl/lsu_byte_serial.sv
// lsu_byte_serial: byte-serial RISC-V load/store initiator between execute stage and a byte-array data memory
//
// Each accepted load/store is issued as 1, 2 or 4 single-byte memory cycles.
// This makes misaligned accesses legal and independent of memory lane packing.
// One response pulse follows the last byte.
// Illegal funct3 and out-of-range accesses are rejected without touching memory.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned H/HU/SH and W/SW accesses.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE with rst low)
//   req_we, req_funct3       store flag, RV32I width/sign code
//   req_addr, req_wdata      byte address, store data (low bytes used)
//   resp_valid               one-cycle response pulse
//   resp_err                 access rejected
//   resp_rdata               extended load result (0 for stores and errors)
//   dm_rd_ctrl, dm_wr_ctrl   memory byte read / byte write strobes
//   dm_addr, dm_din          memory byte address and store byte
//   dm_dout                  combinational memory read data, [7:0] used
module lsu_byte_serial #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [2:0]        dm_rd_ctrl,
    output logic [1:0]        dm_wr_ctrl,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    input  logic [31:0]       dm_dout
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, err_q;
    logic [2:0]        f3_q, n_q;
    logic [1:0]        i_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q;

    logic              accept, reject, illegal, oob, misalign, last_byte;
    logic [2:0]        n_req;
    logic [ADDR_W:0]   last_addr;
    logic              unused_dout;

    assign unused_dout = ^dm_dout[31:8];

    assign n_req = req_funct3[1:0] == 2'b00 ? 3'd1 : req_funct3[1:0] == 2'b01 ? 3'd2 : 3'd4;
    assign illegal = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2]);
    // One extra bit so an access near the top of the address space cannot wrap into range.
    assign last_addr = {1'b0, req_addr} + (ADDR_W+1)'(n_req) - (ADDR_W+1)'(1);
    assign oob = last_addr >= (ADDR_W+1)'(MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign reject    = illegal || oob || misalign;
    assign accept    = req_valid && req_ready;
    assign last_byte = {1'b0, i_q} == n_q - 3'd1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            n_q     <= '0;
            i_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            err_q   <= reject;
            f3_q    <= req_funct3;
            n_q     <= n_req;
            i_q     <= '0;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
        end else if (state_q == ACCESS) begin
            i_q <= i_q + 2'd1;
            if (!we_q) rdata_q[{i_q, 3'b000} +: 8] <= dm_dout[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (reject ? RESP : ACCESS) : IDLE;
            ACCESS:  state_d = last_byte ? RESP : ACCESS;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every output is forced quiet while rst is high, whatever the state register holds.
    always_comb begin
        req_ready  = !rst && state_q == IDLE;
        resp_valid = !rst && state_q == RESP;
        resp_err   = resp_valid && err_q;
        resp_rdata = '0;
        if (resp_valid && !err_q && !we_q)
            resp_rdata = f3_q == 3'b000 ? {{24{rdata_q[7]}}, rdata_q[7:0]} :
                         f3_q == 3'b001 ? {{16{rdata_q[15]}}, rdata_q[15:0]} :
                         f3_q == 3'b100 ? {24'b0, rdata_q[7:0]} :
                         f3_q == 3'b101 ? {16'b0, rdata_q[15:0]} : rdata_q;
        dm_rd_ctrl = (!rst && state_q == ACCESS && !we_q) ? 3'b010 : 3'b000;
        dm_wr_ctrl = (!rst && state_q == ACCESS && we_q) ? 2'b01 : 2'b00;
        dm_addr    = (!rst && state_q == ACCESS) ? addr_q + ADDR_W'(i_q) : '0;
        dm_din     = (dm_wr_ctrl == 2'b01) ? {24'b0, wdata_q[{i_q, 3'b000} +: 8]} : '0;
    end
endmodule
